// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 signed max-pooling over a raster-ordered feature
//   map of IMG_W x IMG_H pixels, ARR_INPUTS lanes of DATA_WIDTH bits each.
//   Emits one pooled pixel per window: (IMG_W/2) x (IMG_H/2) outputs/frame.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a valid pixel
//   in_ready   block accepts in_data this cycle (= !out_valid || out_ready)
//   in_data    packed pixel, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out_data holds a pooled pixel
//   out_ready  downstream accepts out_data
//   out_data   pooled pixel, same packing as in_data
//   out_last   marks the final pooled pixel of the frame
module maxpool2x2_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ARR_INPUTS = 16,
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*ARR_INPUTS-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*ARR_INPUTS-1:0] out_data,
  output logic                             out_last
);

  localparam int unsigned PW       = DATA_WIDTH * ARR_INPUTS;
  localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LB_DEPTH = IMG_W / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;

  row_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PW-1:0]    pa_q, pa_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  // Half-row buffer of horizontal pair maxima from the even row.
  logic [PW-1:0]    lb_q [LB_DEPTH];
  logic [LB_AW-1:0] lb_idx;
  logic             lb_we;

  logic [PW-1:0]    h_max;
  logic [PW-1:0]    win_max;
  logic             in_fire;
  logic             col_end;
  logic             row_end;

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign in_ready  = !out_valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign col_end   = (col_q == COL_W'(IMG_W - 1));
  assign row_end   = (row_q == ROW_W'(IMG_H - 1));
  assign lb_idx    = LB_AW'(col_q >> 1);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    h_max   = '0;
    win_max = '0;
    for (int unsigned k = 0; k < ARR_INPUTS; k++) begin
      h_max[k*DATA_WIDTH +: DATA_WIDTH]   = smax(pa_q[k*DATA_WIDTH +: DATA_WIDTH],
                                                 in_data[k*DATA_WIDTH +: DATA_WIDTH]);
      win_max[k*DATA_WIDTH +: DATA_WIDTH] = smax(lb_q[lb_idx][k*DATA_WIDTH +: DATA_WIDTH],
                                                 h_max[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pa_d        = pa_q;
    lb_we       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (in_fire) begin
      if (!col_q[0]) begin
        pa_d = in_data;
      end else if (state_q == ROW_EVEN) begin
        lb_we = 1'b1;
      end else begin
        // A completing window reloads the output even on the cycle the
        // previous result is being taken, keeping full throughput.
        out_valid_d = 1'b1;
        out_data_d  = win_max;
        out_last_d  = row_end && col_end;
      end

      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d   = '0;
          state_d = ROW_EVEN;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ROW_EVEN;
      col_q       <= '0;
      row_q       <= '0;
      pa_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pa_q        <= pa_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Contents are rewritten every even row before being read, so no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= h_max;
    end
  end

endmodule
